// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared widths, owner codes and FSM encoding for the memory arbiter
package mem_if_pkg;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester grant, round-robin on ties or fixed D-priority
module rr_arbiter2
    import mem_if_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_owner,
    output logic grant_d
);
    assign grant_d = req_d & (~req_i | (PRIO_MODE != 0) | (last_owner == OWNER_I));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered memory port between I-cache and D-cache
module mem_arbiter #(
    parameter int ADDR_W = mem_if_pkg::ADDR_W,
    parameter int DATA_W = mem_if_pkg::DATA_W,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              ic_mem_read,
    input  logic              ic_mem_write,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    input  logic [DATA_W-1:0] ic_mem_wdata,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner,
    output logic              busy,
    output logic [CNT_W-1:0]  ic_grant_cnt,
    output logic [CNT_W-1:0]  dc_grant_cnt
);
    import mem_if_pkg::*;

    logic state;
    logic req_i;
    logic req_d;
    logic gnt_d;

    assign req_i = ic_mem_read | ic_mem_write;
    assign req_d = dc_mem_read | dc_mem_write;
    assign busy = state == BUSY;

    rr_arbiter2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .req_i(req_i),
        .req_d(req_d),
        .last_owner(owner),
        .grant_d(gnt_d)
    );

    // ready and data reach only the owner; the other cache sees zeros
    assign ic_mem_ready = mem_ready & busy & (owner == OWNER_I);
    assign dc_mem_ready = mem_ready & busy & (owner == OWNER_D);
    assign ic_mem_rdata = owner == OWNER_I ? mem_rdata : '0;
    assign dc_mem_rdata = owner == OWNER_D ? mem_rdata : '0;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state <= IDLE;
            owner <= OWNER_I;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            ic_grant_cnt <= '0;
            dc_grant_cnt <= '0;
        end else if (state == IDLE) begin
            if (req_i | req_d) begin
                state <= BUSY;
                owner <= gnt_d;
                mem_addr <= gnt_d ? dc_mem_addr : ic_mem_addr;
                mem_wdata <= gnt_d ? dc_mem_wdata : ic_mem_wdata;
                mem_write <= gnt_d ? dc_mem_write : ic_mem_write;
                mem_read <= gnt_d ? dc_mem_read & ~dc_mem_write : ic_mem_read & ~ic_mem_write;
            end
        end else if (mem_ready) begin
            state <= IDLE;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            if (owner == OWNER_D) dc_grant_cnt <= dc_grant_cnt + 1'b1;
            else ic_grant_cnt <= ic_grant_cnt + 1'b1;
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit off-chip memory port between the instruction cache and the data cache.
- Each cache keeps its native memory handshake: hold mem_read or mem_write until mem_ready, with data valid in the ready cycle.
- The arbiter grants one cache at a time, registers the granted request toward memory, and routes ready/rdata back to the owner only.
- Sits between the two cache instances and the memory model in the CPU top level.

Parameters:
- ADDR_W, 28, block address width (word address >> 2).
- DATA_W, 128, cache-line width.
- PRIO_MODE, 0, 0 = round-robin on simultaneous requests; 1 = fixed priority, D-cache wins.
- CNT_W, 16, width of the per-port grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- proc_reset_n  in  1  asynchronous active-low reset.
- ic_mem_read  in  1  I-cache line read request.
- ic_mem_write  in  1  I-cache write request (legal, normally 0).
- ic_mem_addr  in  ADDR_W  I-cache block address.
- ic_mem_wdata  in  DATA_W  I-cache write line.
- ic_mem_rdata  out  DATA_W  read line to I-cache.
- ic_mem_ready  out  1  completion pulse to I-cache.
- dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata, dc_mem_rdata, dc_mem_ready: same set for the D-cache.
- mem_read  out  1  registered read strobe to memory.
- mem_write  out  1  registered write strobe to memory.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write line.
- mem_rdata  in  DATA_W  memory read line.
- mem_ready  in  1  memory completion pulse.
- owner  out  1  current/last grant: 0 = I, 1 = D.
- busy  out  1  high while a transaction is outstanding.
- ic_grant_cnt, dc_grant_cnt  out  CNT_W  completed-transaction counters, wrap at 2^CNT_W.

Behaviour:
- Reset (async, proc_reset_n = 0):
  - state = IDLE.
  - mem_read, mem_write, busy = 0; mem_addr, mem_wdata = 0.
  - owner = 0, with last grant treated as I, so the first tie goes to D in round-robin.
  - Both counters = 0; ic/dc_mem_ready = 0.
  - Reset mid-transaction abandons it immediately; memory sees the strobes drop.
- States: IDLE, BUSY.
- IDLE:
  - Request per port is req_x = x_mem_read | x_mem_write.
  - No request: stay in IDLE, all mem strobes 0.
  - One port requesting: grant it.
  - Both requesting, PRIO_MODE = 0: grant the port that is not the previous owner.
  - Both requesting, PRIO_MODE = 1: grant D.
  - On the grant edge, latch mem_addr, mem_wdata, mem_write = x_mem_write and mem_read = x_mem_read & ~x_mem_write (write wins if both are set), then set owner, busy = 1 and state = BUSY.
  - Grant latency: the request is seen in cycle N, and the memory strobe is high from cycle N+1.
- BUSY:
  - mem_* outputs are held constant, independent of requester inputs.
  - x_mem_ready = mem_ready & busy & (owner == x), combinational.
  - x_mem_rdata = mem_rdata for the owner and 0 for the non-owner.
  - On the edge with mem_ready = 1: clear mem_read and mem_write, busy = 0, increment the owner's counter, state = IDLE.
- Turnaround: at least one IDLE cycle between transactions. This lets the caches update their request after ready; e.g. D-cache WRITE_BACK -> ALLOCATE re-arbitrates as a fresh read.
- Non-owner requests keep waiting. The non-owner never sees ready, even while mem_ready = 1.
- Owner dropping its request during BUSY: the transaction still completes at mem_ready and the ready pulse is still routed; the cache ignores it.
- mem_ready while IDLE: ignored; no ready is routed and no counter changes.
- Starvation bound (round-robin): a waiting port is granted within one foreign transaction.

Decomposition:
- Shared package (mem_if_pkg): ADDR_W/DATA_W constants, OWNER_I = 0 / OWNER_D = 1, state encoding IDLE/BUSY.
- One natural sub-module: rr_arbiter2, a combinational two-requester grant with a last-owner input and PRIO_MODE. The top level holds the FSM, request registers, routing and counters.

Test Plan:
- Single I read: ic_mem_read = 1, addr 0x0000010, memory ready after 3 cycles with rdata 0xDEADBEEF_...
  -> mem_read rises 1 cycle after the request; ic_mem_ready pulses once with that data; dc_mem_ready stays 0; ic_grant_cnt = 1.
- Simultaneous I read and D write, PRIO_MODE = 0, after reset:
  -> D is granted first (mem_write = 1, addr = dc addr); then one IDLE cycle; then I is granted; counters I = 1, D = 1.
- PRIO_MODE = 1 with D continuously requesting 3 transactions and I continuously requesting:
  -> D gets all 3 before I; mem_addr never changes mid-BUSY.
- D-cache write-back followed by allocate (write 0x1234567 then read 0x2000000) while I is also requesting, round-robin:
  -> order is D-write, I-read, D-read.
- Reset asserted 2 cycles into a BUSY read:
  -> mem_read = 0 immediately (async), state IDLE, counters 0, no ready routed.
- Spurious mem_ready in IDLE, and both read & write set by one port:
  -> no ready/counter change; the dual-set request is issued as mem_write = 1, mem_read = 0.
